mem_wb_skid_reg: RTL and testbench
==================================

Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline boundary register for the next-generation core.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a write-back stall does not combinationally back-propagate.
- Adds an internal write-back source select (ALU vs memory), flush, r0 write suppression, forwarding taps and a saturating stall counter.
- Sits between the MEM stage and the register-file write port; the forwarding unit reads its taps.

Parameters:
- DATA_W, 32, width of ALU and memory data buses.
- RD_W, 5, width of destination register index.
- ZERO_SUPPRESS, 1, when 1 any entry with rd==0 is captured with regwre forced to 0.
- CNT_W, 16, width of stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  register can accept; registered, not combinational from out_ready.
- in_regwre  in  1  entry writes register file.
- in_mem_to_reg  in  1  1: select in_mem_data, 0: select in_alu_data.
- in_rd  in  RD_W  destination register.
- in_alu_data  in  DATA_W  ALU result.
- in_mem_data  in  DATA_W  load data.
- out_valid  out  1  WB entry valid.
- out_ready  in  1  WB/register file accepts the entry.
- out_regwre  out  1  write enable; qualify with out_valid.
- out_rd  out  RD_W  write-back register.
- out_data  out  DATA_W  selected write-back data.
- fwd_valid  out  1  equals out_valid && out_regwre.
- fwd_rd  out  RD_W  equals out_rd.
- fwd_data  out  DATA_W  equals out_data.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.

Behaviour:
- Handshakes:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- Data selection at capture, stored per entry:
  - data = in_mem_to_reg ? in_mem_data : in_alu_data.
  - regwre = in_regwre && !(ZERO_SUPPRESS && in_rd==0).
- Storage:
  - main entry drives all out_* ports.
  - skid entry is a holding slot.
  - occupancy state EMPTY/ONE/TWO.
  - out_valid = (state != EMPTY); in_ready = (state != TWO).
- Transitions (flush not asserted):
  - EMPTY: in_fire -> ONE, input loaded to main.
  - ONE, in_fire && out_fire: stay ONE, main reloaded with input.
  - ONE, in_fire && !out_fire: -> TWO, input loaded to skid, main held.
  - ONE, !in_fire && out_fire: -> EMPTY.
  - ONE, neither: hold.
  - TWO: in_fire impossible (in_ready=0). out_fire -> ONE, skid copied to main. Otherwise hold.
- Latency: entry into an EMPTY or draining-ONE register appears on out_* the next cycle. Throughput is 1 per cycle while out_ready=1.
- Flush:
  - Highest priority; next state EMPTY.
  - Any in_fire in the same cycle is dropped.
  - Payload registers may keep stale values, but out_valid and fwd_valid must be 0.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready; otherwise holds.
  - Holds at 2^CNT_W-1 when saturated.
  - Cleared only by reset.
- Reset (RST low, asynchronous):
  - state EMPTY, out_valid=0, in_ready=1.
  - out_regwre=0, out_rd=0, out_data=0; skid payload=0.
  - fwd_*=0, stall_cnt=0.
  - Reset mid-transfer discards both entries immediately.
- Ordering: entries exit in capture order. No entry is duplicated or lost except by flush or reset.

Test Plan:
- Reset, then a stream: out_ready=1, send rd=3 alu=0x11 mem_to_reg=0, then rd=4 mem=0xA5A5A5A5 mem_to_reg=1 -> cycle+1 out rd=3 data=0x11; cycle+2 out rd=4 data=0xA5A5A5A5; in_ready stays 1.
- Skid: out_ready=0, send A(rd=5, 0x55), then B(rd=6, 0x66) -> state TWO, in_ready=0, out shows A. Raise out_ready -> A retires, then B, then out_valid=0; stall_cnt counts the held cycles exactly.
- r0 suppression: send rd=0 regwre=1 data=0xFF -> out_valid=1, out_regwre=0, fwd_valid=0. With ZERO_SUPPRESS=0 -> out_regwre=1.
- Flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1. The new input and both held entries never appear.
- Asynchronous reset asserted mid-cycle while state ONE -> out_valid, out_data and stall_cnt drop to 0 without waiting for a CLK edge.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/mem_wb_skid_reg_if.sv
// MEM/WB boundary bus: MEM-side entry handshake and WB-side write-back handshake.
// Both handshakes are strict valid/ready: a transfer happens on a rising CLK edge
// where valid && ready; a payload is only meaningful while its valid is high.
interface mem_wb_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwre;
  logic              in_mem_to_reg;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_mem_data;

  logic              out_valid;
  logic              out_ready;
  logic              out_regwre;
  logic [RD_W-1:0]   out_rd;
  logic [DATA_W-1:0] out_data;

  // Pipeline environment: produces MEM entries and consumes WB entries.
  modport master (
    output in_valid, in_regwre, in_mem_to_reg, in_rd, in_alu_data, in_mem_data,
    input  in_ready,
    input  out_valid, out_regwre, out_rd, out_data,
    output out_ready
  );

  // Boundary register itself.
  modport slave (
    input  in_valid, in_regwre, in_mem_to_reg, in_rd, in_alu_data, in_mem_data,
    output in_ready,
    output out_valid, out_regwre, out_rd, out_data,
    input  out_ready
  );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a 2-entry skid buffer, write-back data select,
// flush, r0 write suppression, forwarding taps and a saturating stall counter.
module mem_wb_skid_reg #(
  parameter int DATA_W        = 32,
  parameter int RD_W          = 5,
  parameter bit ZERO_SUPPRESS = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  mem_wb_skid_reg_if.slave  bus,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              main_regwre, skid_regwre;
  logic [RD_W-1:0]   main_rd, skid_rd;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              in_fire, out_fire;
  logic              load_main_in, load_skid, main_from_skid;
  logic              cap_regwre;
  logic [DATA_W-1:0] cap_data;

  // in_ready decodes the occupancy register only, so out_ready never reaches it.
  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;

  assign cap_data   = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_data;
  assign cap_regwre = bus.in_regwre && !(ZERO_SUPPRESS && (bus.in_rd == '0));

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: load_main_in = 1'b1;
          2'b10: begin
            state_d   = TWO;
            load_skid = 1'b1;
          end
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; payloads may stay stale behind out_valid=0.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      main_regwre <= 1'b0;
      main_rd     <= '0;
      main_data   <= '0;
      skid_regwre <= 1'b0;
      skid_rd     <= '0;
      skid_data   <= '0;
    end else begin
      if (load_main_in) begin
        main_regwre <= cap_regwre;
        main_rd     <= bus.in_rd;
        main_data   <= cap_data;
      end else if (main_from_skid) begin
        main_regwre <= skid_regwre;
        main_rd     <= skid_rd;
        main_data   <= skid_data;
      end
      if (load_skid) begin
        skid_regwre <= cap_regwre;
        skid_rd     <= bus.in_rd;
        skid_data   <= cap_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.out_regwre = main_regwre;
  assign bus.out_rd     = main_rd;
  assign bus.out_data   = main_data;
  assign fwd_valid      = bus.out_valid && main_regwre;
  assign fwd_rd         = main_rd;
  assign fwd_data       = main_data;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: two instances (r0 suppression on/off, 4-bit counter)
// share one stimulus stream and are checked against an in-order queue model.
module tb_mem_wb_skid_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          we_a;
    logic          we_b;
  } ent_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic flush = 1'b0;

  logic          fwd_valid_a, fwd_valid_b;
  logic [RW-1:0] fwd_rd_a, fwd_rd_b;
  logic [DW-1:0] fwd_data_a, fwd_data_b;
  logic [CW-1:0] stall_a, stall_b;
  logic [1:0]    dbg_a, dbg_b;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t          exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  mem_wb_skid_reg_if #(.DATA_W(DW), .RD_W(RW)) bus_a ();
  mem_wb_skid_reg_if #(.DATA_W(DW), .RD_W(RW)) bus_b ();

  assign bus_b.in_valid      = bus_a.in_valid;
  assign bus_b.in_regwre     = bus_a.in_regwre;
  assign bus_b.in_mem_to_reg = bus_a.in_mem_to_reg;
  assign bus_b.in_rd         = bus_a.in_rd;
  assign bus_b.in_alu_data   = bus_a.in_alu_data;
  assign bus_b.in_mem_data   = bus_a.in_mem_data;
  assign bus_b.out_ready     = bus_a.out_ready;

  mem_wb_skid_reg #(.DATA_W(DW), .RD_W(RW), .ZERO_SUPPRESS(1'b1), .CNT_W(CW)) u_a (
    .CLK(CLK), .RST(RST), .flush(flush), .bus(bus_a.slave),
    .fwd_valid(fwd_valid_a), .fwd_rd(fwd_rd_a), .fwd_data(fwd_data_a),
    .stall_cnt(stall_a), .dbg_state(dbg_a)
  );

  mem_wb_skid_reg #(.DATA_W(DW), .RD_W(RW), .ZERO_SUPPRESS(1'b0), .CNT_W(CW)) u_b (
    .CLK(CLK), .RST(RST), .flush(flush), .bus(bus_b.slave),
    .fwd_valid(fwd_valid_b), .fwd_rd(fwd_rd_b), .fwd_data(fwd_data_b),
    .stall_cnt(stall_b), .dbg_state(dbg_b)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives inputs 1 unit after the falling edge, returns 2 units after it.
  task automatic step(input logic v, input logic we, input logic m2r,
                      input logic [RW-1:0] rd, input logic [DW-1:0] alu,
                      input logic [DW-1:0] mem, input logic ordy, input logic fl);
    @(negedge CLK);
    #1;
    bus_a.in_valid      = v;
    bus_a.in_regwre     = we;
    bus_a.in_mem_to_reg = m2r;
    bus_a.in_rd         = rd;
    bus_a.in_alu_data   = alu;
    bus_a.in_mem_data   = mem;
    bus_a.out_ready     = ordy;
    flush               = fl;
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Model: held entries are a FIFO of at most two, in capture order.
  always begin
    @(negedge CLK);
    #2;
    if (!RST) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      logic in_acc, out_acc;
      check("out_valid", 64'(bus_a.out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(bus_a.in_ready), 64'(exp_q.size() < 2));
      check("twin_valid", 64'(bus_b.out_valid), 64'(exp_q.size() != 0));
      check("stall_cnt_a", 64'(stall_a), 64'(exp_cnt));
      check("stall_cnt_b", 64'(stall_b), 64'(exp_cnt));
      if (exp_q.size() != 0) begin
        check("out_rd", 64'(bus_a.out_rd), 64'(exp_q[0].rd));
        check("out_data", 64'(bus_a.out_data), 64'(exp_q[0].data));
        check("out_regwre_a", 64'(bus_a.out_regwre), 64'(exp_q[0].we_a));
        check("out_regwre_b", 64'(bus_b.out_regwre), 64'(exp_q[0].we_b));
        check("fwd_valid_a", 64'(fwd_valid_a), 64'(exp_q[0].we_a));
        check("fwd_valid_b", 64'(fwd_valid_b), 64'(exp_q[0].we_b));
        check("fwd_rd", 64'(fwd_rd_a), 64'(exp_q[0].rd));
        check("fwd_data", 64'(fwd_data_b), 64'(exp_q[0].data));
      end else begin
        check("fwd_valid_empty", 64'({fwd_valid_a, fwd_valid_b}), 64'(0));
      end

      in_acc  = bus_a.in_valid && (exp_q.size() < 2);
      out_acc = (exp_q.size() != 0) && bus_a.out_ready;
      if ((exp_q.size() != 0) && !bus_a.out_ready && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'd1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_acc) void'(exp_q.pop_front());
        if (in_acc) begin
          ent_t e;
          e.rd   = bus_a.in_rd;
          e.data = bus_a.in_mem_to_reg ? bus_a.in_mem_data : bus_a.in_alu_data;
          e.we_b = bus_a.in_regwre;
          e.we_a = bus_a.in_regwre && (bus_a.in_rd != 0);
          exp_q.push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic          hold;
    logic          c_v, c_we, c_m2r;
    logic [RW-1:0] c_rd;
    logic [DW-1:0] c_alu, c_mem;

    bus_a.in_valid = 1'b0; bus_a.in_regwre = 1'b0; bus_a.in_mem_to_reg = 1'b0;
    bus_a.in_rd = '0; bus_a.in_alu_data = '0; bus_a.in_mem_data = '0;
    bus_a.out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #3 RST = 1'b1;

    // Stream at full throughput
    step(1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 1'b1, 1'b0);
    check("reset_out_valid", 64'(bus_a.out_valid), 64'(0));
    check("reset_in_ready", 64'(bus_a.in_ready), 64'(1));
    check("reset_payload", 64'({bus_a.out_regwre, bus_a.out_rd, bus_a.out_data}), 64'(0));
    check("reset_stall", 64'(stall_a), 64'(0));
    step(1'b1, 1'b1, 1'b1, 5'd4, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0);
    check("stream_rd3", 64'({bus_a.out_valid, bus_a.out_rd}), 64'({1'b1, 5'd3}));
    check("stream_d11", 64'(bus_a.out_data), 64'(32'h11));
    idle(1'b1);
    check("stream_rd4", 64'({bus_a.out_valid, bus_a.out_rd}), 64'({1'b1, 5'd4}));
    check("stream_dA5", 64'(bus_a.out_data), 64'(32'hA5A5A5A5));
    check("stream_in_ready", 64'(bus_a.in_ready), 64'(1));
    idle(1'b1);
    check("stream_drained", 64'(bus_a.out_valid), 64'(0));

    // Skid: fill both entries while WB stalls
    step(1'b1, 1'b1, 1'b0, 5'd5, 32'h55, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0, 1'b0, 1'b0);
    check("skid_one_ready", 64'(bus_a.in_ready), 64'(1));
    idle(1'b0);
    check("skid_two_ready", 64'(bus_a.in_ready), 64'(0));
    check("skid_two_outA", 64'({bus_a.out_rd, bus_a.out_data}), 64'({5'd5, 32'h55}));
    check("skid_cnt1", 64'(stall_a), 64'(1));
    idle(1'b0);
    check("skid_cnt2", 64'(stall_a), 64'(2));
    idle(1'b1);
    check("skid_cnt3", 64'(stall_a), 64'(3));
    check("skid_still_A", 64'(bus_a.out_rd), 64'(5));
    idle(1'b1);
    check("skid_outB", 64'({bus_a.out_valid, bus_a.out_rd, bus_a.out_data}), 64'({1'b1, 5'd6, 32'h66}));
    idle(1'b1);
    check("skid_empty", 64'(bus_a.out_valid), 64'(0));
    check("skid_cnt_final", 64'(stall_a), 64'(3));

    // r0 suppression
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'hFF, 32'h0, 1'b1, 1'b0);
    idle(1'b1);
    check("r0_valid", 64'(bus_a.out_valid), 64'(1));
    check("r0_regwre_supp", 64'({bus_a.out_regwre, fwd_valid_a}), 64'(0));
    check("r0_regwre_nosupp", 64'({bus_b.out_regwre, fwd_valid_b}), 64'(2'b11));

    // Flush while full with a new input offered
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd8, 32'h88, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0, 1'b1);
    check("flush_pre_full", 64'(bus_a.in_ready), 64'(0));
    idle(1'b1);
    check("flush_valid", 64'({bus_a.out_valid, fwd_valid_a, fwd_valid_b}), 64'(0));
    check("flush_ready", 64'(bus_a.in_ready), 64'(1));
    idle(1'b1);
    check("flush_nothing_left", 64'(bus_a.out_valid), 64'(0));

    // Counter saturation, then asynchronous reset while holding one entry
    step(1'b1, 1'b1, 1'b0, 5'd10, 32'hCAFE, 32'h0, 1'b0, 1'b0);
    repeat (20) idle(1'b0);
    check("sat_cnt", 64'(stall_a), 64'(15));
    check("sat_held", 64'({bus_a.out_valid, bus_a.out_data}), 64'({1'b1, 32'hCAFE}));
    #1 RST = 1'b0;
    #1;
    check("arst_valid", 64'({bus_a.out_valid, fwd_valid_a}), 64'(0));
    check("arst_data", 64'({bus_a.out_rd, bus_a.out_data}), 64'(0));
    check("arst_cnt", 64'(stall_a), 64'(0));
    check("arst_ready", 64'(bus_a.in_ready), 64'(1));
    @(negedge CLK);
    #3 RST = 1'b1;

    // Randomised traffic; a refused entry is held stable until accepted
    hold = 1'b0;
    c_v = 1'b0; c_we = 1'b0; c_m2r = 1'b0; c_rd = '0; c_alu = '0; c_mem = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        c_v   = ($urandom_range(0, 3) != 0);
        c_we  = ($urandom_range(0, 4) != 0);
        c_m2r = ($urandom_range(0, 1) != 0);
        c_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        c_alu = $urandom;
        c_mem = $urandom;
      end
      step(c_v, c_we, c_m2r, c_rd, c_alu, c_mem,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      hold = bus_a.in_valid && !bus_a.in_ready && !flush;
    end
    repeat (4) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
